// File: rtl/uart_program_loader.sv
// Boot loader: receives a framed program image over 8N1 UART and writes it into
// memory through a dedicated write port, holding the CPU in reset until it checks out.
module uart_program_loader #(
    parameter int unsigned CLKS_PER_BIT = 234,
    parameter logic [15:0] BASE_ADDR    = 16'h0000,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned TIMEOUT_BITS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        mem_we,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int unsigned TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned TO_W     = $clog2(TO_LIMIT + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_LIMIT - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        HUNT,
        LEN_HI,
        LEN_LO,
        DATA,
        CSUM
    } frame_state_t;

    // Receiver state
    logic             r_rx_meta;
    logic             r_rx_sync;
    logic             r_rx_prev;
    rx_state_t        r_rx_state;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_byte_valid;
    logic [7:0]       r_byte;
    logic             r_frame_err;

    // Frame state
    frame_state_t     r_state;
    logic [7:0]       r_len_hi;
    logic [15:0]      r_remaining;
    logic [7:0]       r_sum;
    logic [TO_W-1:0]  r_idle_cnt;
    logic [15:0]      r_mem_addr;
    logic [7:0]       r_mem_data;
    logic             r_mem_we;
    logic             r_cpu_hold;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic             w_timeout;
    logic [15:0]      w_len;

    assign w_timeout = (r_state != HUNT) && (r_idle_cnt == TO_LAST);
    assign w_len     = {r_len_hi, r_byte};

    assign mem_addr = r_mem_addr;
    assign mem_data = r_mem_data;
    assign mem_we   = r_mem_we;
    assign cpu_hold = r_cpu_hold;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

    // 8N1 receiver: start validated at half-bit, data and stop sampled at bit centres
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta    <= 1'b1;
            r_rx_sync    <= 1'b1;
            r_rx_prev    <= 1'b1;
            r_rx_state   <= RX_IDLE;
            r_clk_cnt    <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_byte       <= '0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rx_meta    <= rx;
            r_rx_sync    <= r_rx_meta;
            r_rx_prev    <= r_rx_sync;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;

            case (r_rx_state)
                RX_IDLE: begin
                    if (r_rx_prev && !r_rx_sync) begin
                        r_rx_state <= RX_START;
                        r_clk_cnt  <= '0;
                    end
                end
                RX_START: begin
                    if (r_clk_cnt == HALF_LAST) begin
                        r_clk_cnt <= '0;
                        r_bit_idx <= '0;
                        // Line back high at mid start bit means a glitch, not a start
                        r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (r_clk_cnt == BIT_LAST) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {r_rx_sync, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_rx_state <= RX_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (r_clk_cnt == BIT_LAST) begin
                        r_clk_cnt  <= '0;
                        r_rx_state <= RX_IDLE;
                        if (r_rx_sync) begin
                            r_byte_valid <= 1'b1;
                            r_byte       <= r_shift;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // Frame parser, memory write port and boot-status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= HUNT;
            r_len_hi    <= '0;
            r_remaining <= '0;
            r_sum       <= '0;
            r_idle_cnt  <= '0;
            r_mem_addr  <= BASE_ADDR;
            r_mem_data  <= '0;
            r_mem_we    <= 1'b0;
            r_cpu_hold  <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            if (r_mem_we) begin
                r_mem_addr <= r_mem_addr + 16'd1;
            end

            if (r_state == HUNT || r_byte_valid) begin
                r_idle_cnt <= '0;
            end else if (r_idle_cnt != TO_LAST) begin
                r_idle_cnt <= r_idle_cnt + TO_W'(1);
            end

            if (r_state == HUNT) begin
                if (r_byte_valid && r_byte == SYNC_BYTE) begin
                    r_state    <= LEN_HI;
                    r_busy     <= 1'b1;
                    r_cpu_hold <= 1'b1;
                    r_done     <= 1'b0;
                    r_err      <= 1'b0;
                    r_sum      <= '0;
                    r_mem_addr <= BASE_ADDR;
                end
            end else if (r_state == DATA && r_remaining == 16'd0) begin
                // Leave DATA only after the final strobe has dropped
                r_state <= CSUM;
            end else if (r_byte_valid) begin
                case (r_state)
                    LEN_HI: begin
                        r_len_hi <= r_byte;
                        r_state  <= LEN_LO;
                    end
                    LEN_LO: begin
                        r_remaining <= w_len;
                        r_state     <= (w_len == 16'd0) ? CSUM : DATA;
                    end
                    DATA: begin
                        r_mem_data  <= r_byte;
                        r_mem_we    <= 1'b1;
                        r_sum       <= r_sum + r_byte;
                        r_remaining <= r_remaining - 16'd1;
                    end
                    CSUM: begin
                        r_state <= HUNT;
                        r_busy  <= 1'b0;
                        if (r_byte == r_sum) begin
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= HUNT;
                        r_busy  <= 1'b0;
                    end
                endcase
            end else if (r_frame_err || w_timeout) begin
                r_state <= HUNT;
                r_busy  <= 1'b0;
                r_err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: drives UART frames on rx and checks
// memory writes and boot-status outputs against hand-computed values.
module tb_uart_program_loader;

    localparam int unsigned CPB = 8;

    logic        clk;
    logic        rst;
    logic        rx;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_we;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    int checks;
    int errors;
    int dbl_we;
    logic prev_we;
    logic [15:0] wa[$];
    logic [7:0]  wd[$];

    uart_program_loader #(
        .CLKS_PER_BIT(CPB),
        .BASE_ADDR   (16'h0000),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_BITS(64)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .mem_we  (mem_we),
        .cpu_hold(cpu_hold),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-port monitor, sampled mid-cycle
    initial begin
        dbl_we  = 0;
        prev_we = 1'b0;
    end
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_data);
            if (prev_we === 1'b1) dbl_we++;
        end
        prev_we = mem_we;
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input int i, input logic [15:0] a, input logic [7:0] d);
        logic [31:0] obs;
        obs = (i < wa.size()) ? {8'h00, wa[i], wd[i]} : 32'hFFFF_FFFF;
        chk(tag, obs, {8'h00, a, d});
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        rx = 1'b1;
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    task automatic clear_writes();
        wa.delete();
        wd.delete();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rx     = 1'b1;
        rst    = 1'b1;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_addr", mem_addr, 16'h0000);
        chk("rst_data", mem_data, 8'h00);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_hold", cpu_hold, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: basic three-byte load
        clear_writes();
        send_byte(8'hA5, 1'b1);
        settle();
        chk("t1_busy_in_frame", busy, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h66, 1'b1);
        settle();
        chk("t1_nwr", wa.size(), 3);
        chk_wr("t1_wr0", 0, 16'h0000, 8'h11);
        chk_wr("t1_wr1", 1, 16'h0001, 8'h22);
        chk_wr("t1_wr2", 2, 16'h0002, 8'h33);
        chk("t1_done", done, 1'b1);
        chk("t1_err", err, 1'b0);
        chk("t1_hold", cpu_hold, 1'b0);
        chk("t1_busy", busy, 1'b0);
        chk("t1_addr_after", mem_addr, 16'h0003);

        // 2: bad checksum, then a good frame recovers
        clear_writes();
        send_byte(8'hA5, 1'b1);
        settle();
        chk("t2_hold_on_sync", cpu_hold, 1'b1);
        chk("t2_done_cleared", done, 1'b0);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'h20, 1'b1);
        send_byte(8'h31, 1'b1);
        settle();
        chk("t2_nwr", wa.size(), 2);
        chk_wr("t2_wr0", 0, 16'h0000, 8'h10);
        chk_wr("t2_wr1", 1, 16'h0001, 8'h20);
        chk("t2_err", err, 1'b1);
        chk("t2_done", done, 1'b0);
        chk("t2_hold", cpu_hold, 1'b1);
        clear_writes();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h7E, 1'b1);
        send_byte(8'h7E, 1'b1);
        settle();
        chk_wr("t2_good_wr", 0, 16'h0000, 8'h7E);
        chk("t2_good_err", err, 1'b0);
        chk("t2_good_done", done, 1'b1);
        chk("t2_good_hold", cpu_hold, 1'b0);

        // 3: zero length
        clear_writes();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        settle();
        chk("t3_nwr", wa.size(), 0);
        chk("t3_done", done, 1'b1);
        chk("t3_hold", cpu_hold, 1'b0);
        chk("t3_busy", busy, 1'b0);

        // 4: inter-byte timeout
        clear_writes();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h01, 1'b1);
        repeat (400) @(negedge clk);
        chk("t4_busy_before", busy, 1'b1);
        chk("t4_err_before", err, 1'b0);
        repeat (200) @(negedge clk);
        chk("t4_err", err, 1'b1);
        chk("t4_busy", busy, 1'b0);
        chk("t4_hold", cpu_hold, 1'b1);
        chk("t4_nwr", wa.size(), 1);
        chk_wr("t4_wr0", 0, 16'h0000, 8'h01);

        // 5a: junk before sync is ignored
        clear_writes();
        send_byte(8'h3C, 1'b1);
        send_byte(8'hFF, 1'b1);
        settle();
        chk("t5_junk_busy", busy, 1'b0);
        chk("t5_junk_err", err, 1'b1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'h65, 1'b1);
        settle();
        chk("t5_nwr", wa.size(), 2);
        chk_wr("t5_wr0", 0, 16'h0000, 8'hAA);
        chk_wr("t5_wr1", 1, 16'h0001, 8'hBB);
        chk("t5_done", done, 1'b1);

        // 5b: short glitch must not start a byte; a frame sent right after must land
        clear_writes();
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (12) @(negedge clk);
        chk("t5_glitch_busy", busy, 1'b0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h42, 1'b1);
        send_byte(8'h42, 1'b1);
        settle();
        chk("t5_glitch_nwr", wa.size(), 1);
        chk_wr("t5_glitch_wr", 0, 16'h0000, 8'h42);
        chk("t5_glitch_done", done, 1'b1);

        // 5c: framing error inside DATA aborts
        clear_writes();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b0);
        settle();
        chk("t5_ferr_err", err, 1'b1);
        chk("t5_ferr_busy", busy, 1'b0);
        chk("t5_ferr_hold", cpu_hold, 1'b1);
        chk("t5_ferr_nwr", wa.size(), 1);

        // 6: async reset mid-DATA, then a clean reload
        clear_writes();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        settle();
        chk("t6_nwr_pre", wa.size(), 2);
        chk("t6_busy_pre", busy, 1'b1);
        chk("t6_addr_pre", mem_addr, 16'h0002);
        rst = 1'b1;
        #1;
        chk("t6_rst_addr", mem_addr, 16'h0000);
        chk("t6_rst_data", mem_data, 8'h00);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_hold", cpu_hold, 1'b1);
        chk("t6_rst_done", done, 1'b0);
        chk("t6_rst_err", err, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        clear_writes();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h5A, 1'b1);
        send_byte(8'h5B, 1'b1);
        send_byte(8'hB5, 1'b1);
        settle();
        chk("t6_nwr", wa.size(), 2);
        chk_wr("t6_wr0", 0, 16'h0000, 8'h5A);
        chk_wr("t6_wr1", 1, 16'h0001, 8'h5B);
        chk("t6_done", done, 1'b1);
        chk("t6_hold", cpu_hold, 1'b0);

        chk("no_back_to_back_we", dbl_we, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
- Boot-time loader that sits directly upstream of the cpu block's memory.
- Receives a framed program image over a UART serial line and writes each byte into memory through a dedicated write port, ahead of the memory's normal bus interface.
- Holds the CPU in reset (drives pc_rst/mem_rst side via cpu_hold) until a frame has loaded and checksummed correctly.
- Lets the board be reprogrammed without resynthesis.

Parameters:
- CLKS_PER_BIT, 234, clk cycles per UART bit (27 MHz / 115200); minimum 4.
- BASE_ADDR, 16'h0000, memory address of first payload byte.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_BITS, 64, max idle bit-times between bytes inside a frame.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- rx  input  1  UART receive line, idle high, 8N1, LSB first.
- mem_addr  output  16  memory write address.
- mem_data  output  8  memory write data.
- mem_we  output  1  one-cycle write strobe; mem_addr/mem_data valid while high.
- cpu_hold  output  1  high keeps CPU in reset.
- busy  output  1  high while inside a frame (any state except HUNT).
- done  output  1  level; last frame loaded with good checksum.
- err  output  1  level, sticky; last frame failed.

Behaviour:
- Reset values:
  - mem_addr=BASE_ADDR, mem_data=0, mem_we=0, busy=0, done=0, err=0.
  - cpu_hold=1.
  - Receiver and frame FSMs to idle/HUNT.
- rx is passed through a 2-flop synchronizer before use. The synchronizer resets to 1.

UART receiver:
- Start is detected on a synchronized falling edge.
- Re-sample at CLKS_PER_BIT/2. If rx is high there, it is a false start: discard and return to idle.
- Data bits are sampled every CLKS_PER_BIT thereafter, at bit centres.
- Stop bit is sampled at its centre:
  - 1: byte_valid pulses for one cycle.
  - 0: framing error. No byte is delivered. Frame FSM aborts as below.
- The receiver is re-armed immediately after the stop-bit sample.

Frame FSM:
- States: HUNT, LEN_HI, LEN_LO, DATA, CSUM.
- HUNT:
  - byte == SYNC_BYTE: go to LEN_HI. Set cpu_hold=1, done=0, err=0, sum=0, mem_addr=BASE_ADDR.
  - Any other byte is ignored.
- LEN_HI: latch len[15:8], go to LEN_LO.
- LEN_LO: latch len[7:0]. If len==0, go to CSUM; else go to DATA with remaining=len.
- DATA, on each byte:
  - mem_data=byte and mem_we=1 in the cycle after byte_valid. Latency is 1 clk from the byte_valid pulse.
  - mem_addr advances by 1 in the cycle after mem_we. It wraps modulo 2^16.
  - sum=sum+byte (mod 256), remaining decrements.
  - When remaining reaches 0, go to CSUM.
- CSUM:
  - byte == sum: done=1, cpu_hold=0.
  - Otherwise: err=1, cpu_hold stays 1.
  - Either way, return to HUNT.
- SYNC_BYTE inside LEN/DATA/CSUM is treated as ordinary data. There is no resync mid-frame.
- Timeout: in any non-HUNT state, an idle-byte counter counts clk cycles since the last byte_valid. At TIMEOUT_BITS*CLKS_PER_BIT cycles: err=1, go to HUNT, cpu_hold stays 1. Bytes already written are not rolled back.
- Framing error in a non-HUNT state: same abort as timeout. In HUNT it is ignored.
- mem_we is never high on two consecutive cycles.
- mem_we is never high outside DATA.
- busy is 1 exactly when the state is not HUNT.
- After a successful load, cpu_hold stays 0 until the next SYNC_BYTE is received in HUNT or rst is asserted.
- rst mid-frame: all outputs return to reset values immediately (asynchronous). Partial memory contents are left as-is.

Test Plan (CLKS_PER_BIT=8, BASE_ADDR=16'h0000):
1. Reset, then send A5 00 03 11 22 33 66.
   - Writes 11@0000, 22@0001, 33@0002, each a single-cycle mem_we.
   - Ends with done=1, err=0, cpu_hold=0, busy=0.
2. Send A5 00 02 10 20 31 (bad checksum).
   - Two writes occur.
   - Ends with err=1, done=0, cpu_hold=1.
   - A following good frame clears err and sets done.
3. Zero length: send A5 00 00 00.
   - No mem_we.
   - done=1, cpu_hold=0.
4. Timeout: send A5 00 05 01, then hold rx=1 for 64*8 cycles.
   - err=1, busy=0, cpu_hold=1.
   - Exactly one write occurred.
5. Robustness:
   - Send 3C FF before A5 ...: ignored, then normal load.
   - A 3-cycle low glitch on rx in HUNT produces no byte.
   - Stop bit forced 0 during DATA gives err=1.
6. Assert rst during DATA after 2 bytes.
   - Outputs return to reset values within the same cycle.
   - A subsequent full frame loads correctly from 0000.
